instr_sequencer: RTL and testbench

Instruction store-and-playback stage for the robot controller. Sits directly downstream of the key conditioning logic, which turns save, execute and delete presses into single-cycle pulses. Sits directly upstream of the HEX/LEDR display decode. Records up to DEPTH direction/torque instructions, then replays them in order at a fixed step period, presenting the current instruction on registered outputs.

---
 rtl/robot_pkg.sv | 23 ++
 rtl/instr_sequencer_step_timer.sv | 28 ++
 rtl/instr_sequencer.sv | 113 +++++++++++
 tb/tb_instr_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/robot_pkg.sv
// Shared types for the robot controller: instruction encoding and
// sequencer state.
package robot_pkg;

  typedef enum logic [1:0] {
    FWD   = 2'b00,
    REV   = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  // Packed so that instr_in[3:2] is torque and instr_in[1:0] is direction.
  typedef struct packed {
    logic [1:0] torque;
    dir_t       dir;
  } instr_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/instr_sequencer_step_timer.sv
// Playback period timer: counts 0..STEP_CYCLES-1 while enabled and flags
// the last cycle of each period.
module step_timer #(
  parameter int STEP_CYCLES = 50_000_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(STEP_CYCLES);

  logic [W-1:0] cnt;

  assign tick = !clear && (cnt == W'(STEP_CYCLES - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction store-and-playback: records up to DEPTH direction/torque
// instructions in IDLE and replays them in order, one per step period, in RUN.
module instr_sequencer
  import robot_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int STEP_CYCLES = 50_000_000
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       save_pulse,
  input  logic                       delete_pulse,
  input  logic                       execute_pulse,
  input  logic [3:0]                 instr_in,
  output logic [1:0]                 cur_dir,
  output logic [1:0]                 cur_torque,
  output logic                       active,
  output logic                       done_pulse,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  state_t        state;
  instr_t        mem [DEPTH];
  logic [IW-1:0] idx;
  logic [IW-1:0] next_idx;
  logic          last_slot;
  logic          timer_clear;
  logic          tick;

  // Timer is held at zero outside playback so each run starts a fresh period.
  assign timer_clear = (state != RUN);
  assign next_idx    = idx + IW'(1);
  assign last_slot   = ((CW'(idx) + CW'(1)) == count);

  step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step_timer (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .clear   (timer_clear),
    .tick    (tick)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      active     <= 1'b0;
      done_pulse <= 1'b0;
      cur_dir    <= 2'b00;
      cur_torque <= 2'b00;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      done_pulse <= 1'b0;
      case (state)
        IDLE: begin
          // Strict priority: the highest pulse present claims the cycle even
          // when its own action is a no-op.
          if (execute_pulse) begin
            if (!empty) begin
              state      <= RUN;
              idx        <= '0;
              active     <= 1'b1;
              cur_dir    <= mem[0].dir;
              cur_torque <= mem[0].torque;
            end
          end else if (delete_pulse) begin
            if (!empty) begin
              count <= count - CW'(1);
              full  <= 1'b0;
              empty <= (count == CW'(1));
            end
          end else if (save_pulse) begin
            if (!full) begin
              mem[count[IW-1:0]] <= instr_t'(instr_in);
              count <= count + CW'(1);
              full  <= ((count + CW'(1)) == CW'(DEPTH));
              empty <= 1'b0;
            end
          end
        end
        RUN: begin
          if (tick) begin
            if (last_slot) begin
              state      <= IDLE;
              idx        <= '0;
              active     <= 1'b0;
              done_pulse <= 1'b1;
              cur_dir    <= 2'b00;
              cur_torque <= 2'b00;
            end else begin
              idx        <= next_idx;
              cur_dir    <= mem[next_idx].dir;
              cur_torque <= mem[next_idx].torque;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_instr_sequencer;

  localparam int DEPTH = 4;
  localparam int STEP  = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b1;
  logic          save_pulse = 1'b0;
  logic          delete_pulse = 1'b0;
  logic          execute_pulse = 1'b0;
  logic [3:0]    instr_in = 4'h0;
  logic [1:0]    cur_dir;
  logic [1:0]    cur_torque;
  logic          active;
  logic          done_pulse;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  always #5 CLOCK_50 = ~CLOCK_50;

  instr_sequencer #(
    .DEPTH(DEPTH),
    .STEP_CYCLES(STEP)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .save_pulse   (save_pulse),
    .delete_pulse (delete_pulse),
    .execute_pulse(execute_pulse),
    .instr_in     (instr_in),
    .cur_dir      (cur_dir),
    .cur_torque   (cur_torque),
    .active       (active),
    .done_pulse   (done_pulse),
    .count        (count),
    .full         (full),
    .empty        (empty)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the store is a queue; playback position is elapsed
  // cycles since execute divided by the step period.
  logic [3:0] mq[$];
  bit         m_run   = 0;
  int         m_rc    = 0;
  bit         m_done  = 0;
  bit         m_valid = 0;

  always @(posedge CLOCK_50) begin
    if (reset) begin
      mq.delete();
      m_run   = 0;
      m_rc    = 0;
      m_done  = 0;
      m_valid = 1;
    end else begin
      m_done = 0;
      if (m_run) begin
        m_rc++;
        if (m_rc == mq.size() * STEP) begin
          m_run  = 0;
          m_done = 1;
        end
      end else if (execute_pulse) begin
        if (mq.size() > 0) begin
          m_run = 1;
          m_rc  = 0;
        end
      end else if (delete_pulse) begin
        if (mq.size() > 0) void'(mq.pop_back());
      end else if (save_pulse) begin
        if (mq.size() < DEPTH) mq.push_back(instr_in);
      end
    end
  end

  logic [3:0]    play_log[$];
  int            done_cnt = 0;
  logic [3:0]    ecur;
  logic [CW+7:0] exp_vec;
  logic [CW+7:0] act_vec;

  always @(negedge CLOCK_50) begin
    if (m_valid) begin
      ecur    = m_run ? mq[m_rc / STEP] : 4'h0;
      exp_vec = {ecur[3:2], ecur[1:0], m_run, m_done, CW'(mq.size()),
                 (mq.size() == DEPTH), (mq.size() == 0)};
      act_vec = {cur_torque, cur_dir, active, done_pulse, count, full, empty};
      checks++;
      if (act_vec !== exp_vec) begin
        failures++;
        $display("FAIL cycle_compare t=%0t actual=%b expected=%b", $time, act_vec, exp_vec);
      end
      if (active === 1'b1) play_log.push_back({cur_torque, cur_dir});
      if (done_pulse === 1'b1) done_cnt++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic pulse(input bit s, input bit d, input bit e, input logic [3:0] v);
    save_pulse    = s;
    delete_pulse  = d;
    execute_pulse = e;
    instr_in      = v;
    cycles(1);
    save_pulse    = 0;
    delete_pulse  = 0;
    execute_pulse = 0;
    instr_in      = 4'h0;
  endtask

  task automatic do_reset();
    reset = 1;
    cycles(2);
    reset = 0;
  endtask

  task automatic clear_logs();
    play_log.delete();
    done_cnt = 0;
  endtask

  logic [3:0] seq_a[3];
  logic [3:0] seq_b[4];

  initial begin
    seq_a = '{4'h0, 4'h4, 4'hE};
    seq_b = '{4'h1, 4'h6, 4'hB, 4'hF};

    // Reset state
    do_reset();
    cycles(2);
    chk("reset_count", int'(count), 0);
    chk("reset_empty", int'(empty), 1);
    chk("reset_full", int'(full), 0);
    chk("reset_active", int'(active), 0);
    chk("reset_cur", int'({cur_torque, cur_dir}), 0);

    // Record and play: 0/FWD, 1/FWD, 3/LEFT
    clear_logs();
    for (int i = 0; i < 3; i++) pulse(1, 0, 0, seq_a[i]);
    pulse(0, 0, 1, 4'h0);
    cycles(14);
    chk("play_len", play_log.size(), 12);
    for (int i = 0; i < 12 && i < play_log.size(); i++)
      chk($sformatf("play_seq[%0d]", i), int'(play_log[i]), int'(seq_a[i / 4]));
    chk("play_done_cnt", done_cnt, 1);
    chk("play_count_after", int'(count), 3);

    // Full boundary: fifth save ignored, slot 3 untouched
    do_reset();
    clear_logs();
    for (int i = 0; i < 4; i++) pulse(1, 0, 0, seq_b[i]);
    pulse(1, 0, 0, 4'h4);
    chk("full_count", int'(count), 4);
    chk("full_flag", int'(full), 1);
    pulse(0, 0, 1, 4'h0);
    cycles(18);
    chk("full_play_len", play_log.size(), 16);
    if (play_log.size() == 16) chk("full_slot3", int'(play_log[12]), 4'hF);
    chk("full_done_cnt", done_cnt, 1);

    // Empty boundary: five deletes from four
    repeat (5) pulse(0, 1, 0, 4'h0);
    chk("empty_count", int'(count), 0);
    chk("empty_flag", int'(empty), 1);
    chk("empty_full", int'(full), 0);

    // Simultaneous pulses in IDLE
    clear_logs();
    pulse(1, 0, 0, 4'h2);
    pulse(1, 0, 0, 4'h3);
    pulse(1, 1, 0, 4'h5);
    chk("save_del_count", int'(count), 1);
    pulse(1, 0, 1, 4'h9);
    chk("exec_save_active", int'(active), 1);
    chk("exec_save_count", int'(count), 1);
    cycles(6);
    chk("exec_save_len", play_log.size(), 4);
    if (play_log.size() == 4) chk("exec_save_instr", int'(play_log[3]), 4'h2);
    chk("exec_save_done", done_cnt, 1);

    // Pulses during RUN are ignored
    do_reset();
    clear_logs();
    pulse(1, 0, 0, 4'h7);
    pulse(1, 0, 0, 4'h8);
    pulse(1, 0, 0, 4'hD);
    pulse(0, 0, 1, 4'h0);
    cycles(2);
    pulse(1, 0, 0, 4'hC);
    cycles(2);
    pulse(0, 1, 0, 4'h0);
    cycles(2);
    pulse(0, 0, 1, 4'h0);
    cycles(6);
    chk("run_pulse_len", play_log.size(), 12);
    if (play_log.size() == 12) begin
      chk("run_pulse_mid", int'(play_log[4]), 4'h8);
      chk("run_pulse_last", int'(play_log[11]), 4'hD);
    end
    chk("run_pulse_count", int'(count), 3);
    chk("run_pulse_done", done_cnt, 1);

    // Reset mid-RUN at run cycle 6
    clear_logs();
    pulse(0, 0, 1, 4'h0);
    cycles(5);
    reset = 1;
    cycles(1);
    reset = 0;
    chk("midrst_active", int'(active), 0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_empty", int'(empty), 1);
    cycles(10);
    chk("midrst_no_done", done_cnt, 0);
    pulse(0, 0, 1, 4'h0);
    cycles(2);
    chk("midrst_exec_ignored", int'(active), 0);
    chk("midrst_exec_count", int'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
